// File: rtl/apb3toahb_pkg.sv
// Shared types and AHB-Lite encodings for the APB3-to-AHB bridge.
package apb3toahb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StResp
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Word-align the APB address and offset it into the AHB map (wraps mod 2^32).
    function automatic logic [31:0] ahb_addr(input logic [31:0] paddr, input logic [31:0] base);
        return base + {paddr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/apb3_to_ahb_bridge_if.sv
// APB3 completer side plus AHB-Lite manager side of the bridge in one bundle.
// slave: bridge view; master: view of the APB initiator and AHB subordinate.
interface apb3_to_ahb_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADY, HRESP,
        output PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA, HREADY, HRESP,
        input  PRDATA, PREADY, PSLVERR, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/apb3toahb_tmo_cnt.sv
// Data-phase timeout counter: cleared on entry to DATA, counts stalled cycles,
// flags expiry once the count reaches Max. Built only with APB3TOAHB_TMO_EN.
`ifdef APB3TOAHB_TMO_EN
module apb3toahb_tmo_cnt #(
    parameter int unsigned Max = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int unsigned CntW = $clog2(Max + 1);

    logic [CntW-1:0] cnt_q;

    // Count stalled cycles; hold at Max so expiry stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = (cnt_q == CntW'(Max));
endmodule
`endif

// File: rtl/apb3_to_ahb_bridge.sv
// APB3 completer to AHB-Lite manager bridge: each APB transfer becomes one
// AHB SINGLE word transfer; the AHB result returns via PRDATA/PREADY/PSLVERR.
// Optional macro APB3TOAHB_TMO_EN adds a data-phase timeout of TMO_CYCLES.
module apb3_to_ahb_bridge
    import apb3toahb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
`ifdef APB3TOAHB_TMO_EN
    , parameter int unsigned TMO_CYCLES = 256
`endif
) (
    input logic              HCLK,
    input logic              HRESETN,
    apb3_to_ahb_bridge_if.slave bus
);
    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] prdata_q, prdata_d;
    logic        hwrite_q, hwrite_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] paddr_ext;

    assign paddr_ext = 32'(bus.PADDR[ADDR_W-1:0]);

`ifdef APB3TOAHB_TMO_EN
    logic tmo_expire;

    apb3toahb_tmo_cnt #(
        .Max (TMO_CYCLES)
    ) u_tmo_cnt (
        .clk    (HCLK),
        .rst_n  (HRESETN),
        .clr    (state_q == StAddr && bus.HREADY),
        .inc    (state_q == StData && !bus.HREADY),
        .expire (tmo_expire)
    );
`endif

    // Next-state and registered-output updates for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwdata_d  = hwdata_q;
        hwrite_d  = hwrite_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        unique case (state_q)
            StIdle: begin
                // Setup phases outside IDLE are deliberately ignored.
                if (bus.PSEL && !bus.PENABLE) begin
                    haddr_d  = ahb_addr(paddr_ext, BASE_ADDR);
                    hwrite_d = bus.PWRITE;
                    hwdata_d = bus.PWDATA;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                if (bus.HREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bus.HREADY) begin
                    prdata_d  = hwrite_q ? 32'h0 : bus.HRDATA;
                    pslverr_d = (bus.HRESP == HRESP_ERROR);
                    state_d   = StResp;
                end
`ifdef APB3TOAHB_TMO_EN
                else if (tmo_expire) begin
                    // Abandon the stuck data phase on the APB side only.
                    prdata_d  = 32'h0;
                    pslverr_d = 1'b1;
                    state_d   = StResp;
                end
`endif
            end
            StResp: begin
                prdata_d  = 32'h0;
                pslverr_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= StIdle;
            haddr_q   <= 32'h0;
            hwdata_q  <= 32'h0;
            hwrite_q  <= 1'b0;
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwdata_q  <= hwdata_d;
            hwrite_q  <= hwrite_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.HTRANS  = (state_q == StAddr) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.PREADY  = (state_q == StResp);
    assign bus.HADDR   = haddr_q;
    assign bus.HWRITE  = hwrite_q;
    assign bus.HWDATA  = hwdata_q;
    assign bus.HSIZE   = HSIZE_WORD;
    assign bus.HBURST  = HBURST_SINGLE;
    assign bus.PRDATA  = prdata_q;
    assign bus.PSLVERR = pslverr_q;
endmodule

// File: tb/tb_apb3_to_ahb_bridge.sv
// Testbench for apb3_to_ahb_bridge: directed vector table, randomized transfers
// against a transfer-level model, and hand-written reset/timeout sequences.
module tb_apb3_to_ahb_bridge;
    import apb3toahb_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;
`ifdef APB3TOAHB_TMO_EN
    localparam int unsigned TMO = 8;
`endif

    logic HCLK = 1'b0;
    logic HRESETN;
    always #5 HCLK = ~HCLK;

    apb3_to_ahb_bridge_if #(.ADDR_W(32)) bus ();

    apb3_to_ahb_bridge #(
        .ADDR_W     (32),
        .BASE_ADDR  (BASE)
`ifdef APB3TOAHB_TMO_EN
        , .TMO_CYCLES (TMO)
`endif
    ) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;        // AHB wait cycles during the address phase
        int          dw;        // AHB wait cycles during the data phase
        logic        err;       // two-cycle ERROR response (needs dw >= 1)
        logic [31:0] exp_haddr;
        logic [31:0] exp_prdata;
        logic        exp_slverr;
        int          exp_lat;   // cycle index of PREADY, setup cycle = 0
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfer-level reference: address map, read-data/err return and latency.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_haddr  = BASE + (v.addr & 32'hFFFF_FFFC);
        r.exp_prdata = v.write ? 32'h0 : v.rdata;
        r.exp_slverr = v.err;
        r.exp_lat    = 3 + v.aw + v.dw;
        return r;
    endfunction

    function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int aw, input int dw,
                                 input logic e, input logic [31:0] eh, input logic [31:0] ep,
                                 input logic es, input int el);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.rdata = rd; v.aw = aw; v.dw = dw; v.err = e;
        v.exp_haddr = eh; v.exp_prdata = ep; v.exp_slverr = es; v.exp_lat = el;
        return v;
    endfunction

    // Drives one APB transfer and a scheduled AHB subordinate; entered and left
    // one time unit after a rising edge.
    task automatic run_xfer(input vec_t v, input string tag);
        logic last;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = v.write;
        bus.PADDR   = v.addr;
        bus.PWDATA  = v.wdata;
        bus.HREADY  = 1'b1;
        bus.HRESP   = HRESP_OKAY;
        bus.HRDATA  = $urandom;
        @(negedge HCLK);
        chk({tag, " t0_pready"}, 32'(bus.PREADY), 32'h0);
        chk({tag, " t0_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        for (int k = 1; k <= v.exp_lat; k++) begin
            @(posedge HCLK);
            #1;
            bus.PENABLE = 1'b1;
            bus.HRDATA  = $urandom;
            bus.HRESP   = HRESP_OKAY;
            if (k <= v.aw + 1) begin
                bus.HREADY = (k == v.aw + 1);
            end else if (k <= v.aw + v.dw + 2) begin
                last = (k == v.aw + v.dw + 2);
                bus.HREADY = last;
                if (last) bus.HRDATA = v.rdata;
                if (v.err && k >= v.aw + v.dw + 1) bus.HRESP = HRESP_ERROR;
            end else begin
                bus.HREADY = 1'b1;
            end
            @(negedge HCLK);
            if (k == v.exp_lat) begin
                chk($sformatf("%s pready@T%0d", tag, k), 32'(bus.PREADY), 32'h1);
                chk({tag, " pslverr"}, 32'(bus.PSLVERR), 32'(v.exp_slverr));
                chk({tag, " prdata"}, bus.PRDATA, v.exp_prdata);
                chk({tag, " resp_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            end else begin
                chk($sformatf("%s pready_low@T%0d", tag, k), 32'(bus.PREADY), 32'h0);
                if (k <= v.aw + 1) begin
                    chk($sformatf("%s nonseq@T%0d", tag, k), 32'(bus.HTRANS),
                        32'(HTRANS_NONSEQ));
                    chk($sformatf("%s haddr@T%0d", tag, k), bus.HADDR, v.exp_haddr);
                    chk({tag, " hwrite"}, 32'(bus.HWRITE), 32'(v.write));
                    chk({tag, " hsize"}, 32'(bus.HSIZE), 32'(3'b010));
                    chk({tag, " hburst"}, 32'(bus.HBURST), 32'(3'b000));
                end else begin
                    chk($sformatf("%s data_idle@T%0d", tag, k), 32'(bus.HTRANS),
                        32'(HTRANS_IDLE));
                    if (v.write) chk({tag, " hwdata"}, bus.HWDATA, v.wdata);
                end
            end
        end
        @(posedge HCLK);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.HREADY  = 1'b1;
        bus.HRESP   = HRESP_OKAY;
        @(negedge HCLK);
        chk({tag, " post_pready"}, 32'(bus.PREADY), 32'h0);
        chk({tag, " post_pslverr"}, 32'(bus.PSLVERR), 32'h0);
        chk({tag, " post_prdata"}, bus.PRDATA, 32'h0);
        @(posedge HCLK);
        #1;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = mkv(1'b1, 32'h0000_0010, 32'hA5A5_0001, 32'h0, 0, 0, 1'b0,
                     32'h2000_0010, 32'h0, 1'b0, 3);
        tbl[1] = mkv(1'b0, 32'h0000_0024, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b0,
                     32'h2000_0024, 32'hDEAD_BEEF, 1'b0, 6);
        tbl[2] = mkv(1'b1, 32'h0000_0030, 32'h1111_2222, 32'h0, 0, 1, 1'b1,
                     32'h2000_0030, 32'h0, 1'b1, 4);
        tbl[3] = mkv(1'b0, 32'h0000_0034, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0,
                     32'h2000_0034, 32'h0BAD_F00D, 1'b0, 3);
        tbl[4] = mkv(1'b1, 32'h0000_0048, 32'hCAFE_0004, 32'h0, 2, 0, 1'b0,
                     32'h2000_0048, 32'h0, 1'b0, 5);
        tbl[5] = mkv(1'b0, 32'h0000_0013, 32'h0, 32'h5555_AAAA, 1, 2, 1'b0,
                     32'h2000_0010, 32'h5555_AAAA, 1'b0, 6);
        tbl[6] = mkv(1'b0, 32'hF000_0004, 32'h0, 32'h0000_0077, 0, 0, 1'b0,
                     32'h1000_0004, 32'h0000_0077, 1'b0, 3);
        tbl[7] = mkv(1'b0, 32'h0000_0008, 32'h0, 32'hFFFF_FFFF, 0, 2, 1'b1,
                     32'h2000_0008, 32'hFFFF_FFFF, 1'b1, 5);

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0;
        bus.PWDATA = '0; bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY;
        HRESETN = 1'b0;
        #1;
        chk("rst prdata", bus.PRDATA, 32'h0);
        chk("rst pready", 32'(bus.PREADY), 32'h0);
        chk("rst pslverr", 32'(bus.PSLVERR), 32'h0);
        chk("rst haddr", bus.HADDR, 32'h0);
        chk("rst htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rst hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst hwdata", bus.HWDATA, 32'h0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETN = 1'b1;
        @(posedge HCLK);
        #1;

        for (int i = 0; i < 8; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while the data phase is stalled.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 32'h80; bus.PWDATA = 32'h0000_1234;
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1; bus.HREADY = 1'b1;
        @(posedge HCLK); #1;
        bus.HREADY = 1'b0;
        #2;
        HRESETN = 1'b0;
        #1;
        chk("midrst htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("midrst pready", 32'(bus.PREADY), 32'h0);
        chk("midrst haddr", bus.HADDR, 32'h0);
        chk("midrst hwdata", bus.HWDATA, 32'h0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.HREADY = 1'b1;
        @(posedge HCLK); #1;
        HRESETN = 1'b1;
        @(negedge HCLK);
        chk("postrst htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("postrst pready", 32'(bus.PREADY), 32'h0);
        @(posedge HCLK); #1;
        run_xfer(tbl[0], "after_rst");

`ifdef APB3TOAHB_TMO_EN
        begin
            int first = -1;
            logic sv_err = 1'b0;
            logic [31:0] sv_rd = 32'hX;
            bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'h40;
            @(posedge HCLK); #1;
            bus.PENABLE = 1'b1; bus.HREADY = 1'b1; bus.HRDATA = 32'h1234_5678;
            @(posedge HCLK); #1;
            bus.HREADY = 1'b0;
            for (int k = 2; k <= int'(TMO) + 8; k++) begin
                @(negedge HCLK);
                if (bus.PREADY && first < 0) begin
                    first = k; sv_err = bus.PSLVERR; sv_rd = bus.PRDATA;
                end
                @(posedge HCLK); #1;
                if (first >= 0) begin
                    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
                end
            end
            chk("tmo latency", 32'(first), 32'(3 + TMO));
            chk("tmo pslverr", 32'(sv_err), 32'h1);
            chk("tmo prdata", sv_rd, 32'h0);
            bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
            rv = mkv(1'b1, 32'h0000_0050, 32'h0A0A_0B0B, 32'h0, 3, 0, 1'b0,
                     32'h2000_0050, 32'h0, 1'b0, 6);
            run_xfer(rv, "tmo_next");
        end
`endif

        for (int i = 0; i < 40; i++) begin
            rv.write = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.aw    = int'($urandom_range(0, 3));
            rv.dw    = int'($urandom_range(0, 3));
            rv.err   = (rv.dw > 0) && ($urandom_range(0, 3) == 0);
            run_xfer(model(rv), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
